exe_mem_status_stage: RTL and testbench

Registered boundary between the execute stage (ALU) and the memory stage of the ARM pipeline. Captures the ALU result and control bits into the EXE/MEM pipeline register and owns the NZCV status register. It feeds the carry back to the ALU and evaluates the condition field of the instruction in decode against forwarded flags.

---
 rtl/exe_mem_status_stage_pkg.sv | 30 +++
 rtl/exe_mem_status_stage_cond_check.sv | 43 ++++
 rtl/exe_mem_status_stage.sv | 102 ++++++++++
 tb/tb_exe_mem_status_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_status_stage_pkg.sv
// Shared definitions for the EXE/MEM boundary and the decode stage:
//   - bit positions of the N, Z, C and V flags inside the 4-bit status word
//   - the 16 ARM condition-field encodings
package exe_mem_status_stage_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/exe_mem_status_stage_cond_check.sv
// cond_check: evaluates an ARM condition field against a set of NZCV flags.
// Purely combinational.
//   Cond      in  4  condition field
//   Flags     in  4  {N,Z,C,V}, bit 3 = N
//   Cond_Pass out 1  instruction may execute
module cond_check
  import exe_mem_status_stage_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       Cond_Pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  always_comb begin
    Cond_Pass = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: Cond_Pass = w_z;
      COND_NE: Cond_Pass = ~w_z;
      COND_CS: Cond_Pass = w_c;
      COND_CC: Cond_Pass = ~w_c;
      COND_MI: Cond_Pass = w_n;
      COND_PL: Cond_Pass = ~w_n;
      COND_VS: Cond_Pass = w_v;
      COND_VC: Cond_Pass = ~w_v;
      COND_HI: Cond_Pass = w_c & ~w_z;
      COND_LS: Cond_Pass = ~w_c | w_z;
      COND_GE: Cond_Pass = (w_n == w_v);
      COND_LT: Cond_Pass = (w_n != w_v);
      COND_GT: Cond_Pass = ~w_z & (w_n == w_v);
      COND_LE: Cond_Pass = w_z | (w_n != w_v);
      COND_AL: Cond_Pass = 1'b1;
      default: Cond_Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_mem_status_stage.sv
// exe_mem_status_stage: EXE/MEM pipeline register plus the architectural
// NZCV status register.
//   clk, rst (sync, active-high), freeze (hold all state)
//   Valid_in, S, Status_Bits_in      EXE instruction validity / flag update
//   ALU_Res_in, Val_Rm_in, Dest_in   data captured into the pipeline register
//   WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  control captured (gated by Valid_in)
//   Cond                             condition field of the decode instruction
//   Status, C_out                    registered NZCV and its carry bit
//   Cond_Pass                        decode condition vs forwarded flags
//   *_out                            registered pipeline outputs
module exe_mem_status_stage
  import exe_mem_status_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Valid_in,
  input  logic              S,
  input  logic [3:0]        Status_Bits_in,
  input  logic [DATA_W-1:0] ALU_Res_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic [REG_W-1:0]  Dest_in,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [3:0]        Cond,
  output logic [3:0]        Status,
  output logic              C_out,
  output logic              Cond_Pass,
  output logic [DATA_W-1:0] ALU_Res_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic [REG_W-1:0]  Dest_out,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic              Valid_out
);

  logic [3:0]        r_status;
  logic [DATA_W-1:0] r_alu_res;
  logic [DATA_W-1:0] r_val_rm;
  logic [REG_W-1:0]  r_dest;
  logic              r_wb_en;
  logic              r_mem_r_en;
  logic              r_mem_w_en;
  logic              r_valid;

  logic              w_flag_upd;
  logic [3:0]        w_eff_flags;

  assign w_flag_upd = S & Valid_in;

  // Forwarding ignores freeze: a frozen flag-setter still commits before the
  // decode instruction it is being compared against can advance.
  assign w_eff_flags = w_flag_upd ? Status_Bits_in : r_status;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= '0;
      r_alu_res  <= '0;
      r_val_rm   <= '0;
      r_dest     <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_valid    <= 1'b0;
    end else if (!freeze) begin
      r_alu_res  <= ALU_Res_in;
      r_val_rm   <= Val_Rm_in;
      r_dest     <= Dest_in;
      // Bubbles carry data through but never enable side effects.
      r_wb_en    <= WB_EN_in & Valid_in;
      r_mem_r_en <= MEM_R_EN_in & Valid_in;
      r_mem_w_en <= MEM_W_EN_in & Valid_in;
      r_valid    <= Valid_in;
      if (w_flag_upd) begin
        r_status <= Status_Bits_in;
      end
    end
  end

  cond_check u_cond_check (
    .Cond      (Cond),
    .Flags     (w_eff_flags),
    .Cond_Pass (Cond_Pass)
  );

  assign Status       = r_status;
  // Carry to the ALU comes from the register only, keeping the loop registered.
  assign C_out        = r_status[FLAG_C];
  assign ALU_Res_out  = r_alu_res;
  assign Val_Rm_out   = r_val_rm;
  assign Dest_out     = r_dest;
  assign WB_EN_out    = r_wb_en;
  assign MEM_R_EN_out = r_mem_r_en;
  assign MEM_W_EN_out = r_mem_w_en;
  assign Valid_out    = r_valid;

endmodule

// File: tb/tb_exe_mem_status_stage.sv
module tb_exe_mem_status_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, Valid_in, S;
  logic [3:0]  Status_Bits_in;
  logic [31:0] ALU_Res_in, Val_Rm_in;
  logic [3:0]  Dest_in;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [3:0]  Cond;
  logic [3:0]  Status;
  logic        C_out, Cond_Pass;
  logic [31:0] ALU_Res_out, Val_Rm_out;
  logic [3:0]  Dest_out;
  logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, Valid_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [3:0]  status;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        wb, mr, mw, vld;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;   // model of the registered state

  always #5 clk = ~clk;

  exe_mem_status_stage #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Valid_in(Valid_in), .S(S),
    .Status_Bits_in(Status_Bits_in), .ALU_Res_in(ALU_Res_in),
    .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in), .WB_EN_in(WB_EN_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .Cond(Cond),
    .Status(Status), .C_out(C_out), .Cond_Pass(Cond_Pass),
    .ALU_Res_out(ALU_Res_out), .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
    .MEM_W_EN_out(MEM_W_EN_out), .Valid_out(Valid_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference condition evaluation, flags given as {N,Z,C,V}.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  r = z;
      4'd1:  r = !z;
      4'd2:  r = cy;
      4'd3:  r = !cy;
      4'd4:  r = n;
      4'd5:  r = !n;
      4'd6:  r = v;
      4'd7:  r = !v;
      4'd8:  r = cy && !z;
      4'd9:  r = !cy || z;
      4'd10: r = (n ^ v) == 1'b0;
      4'd11: r = (n ^ v) == 1'b1;
      4'd12: r = !z && ((n ^ v) == 1'b0);
      4'd13: r = z || ((n ^ v) == 1'b1);
      4'd14: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] eff_flags();
    return (S && Valid_in) ? Status_Bits_in : m.status;
  endfunction

  // One clock: optionally check Cond_Pass, push the expected next state,
  // clock, then pop and compare against the DUT's registered outputs.
  task automatic step(input bit do_cond);
    exp_t e, got;
    #1;
    if (do_cond) check_eq("cond_pass", 32'(Cond_Pass), 32'(cond_model(Cond, eff_flags())));
    e = m;
    if (rst) begin
      e.status = 4'h0; e.alu = 32'h0; e.rm = 32'h0; e.dest = 4'h0;
      e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.vld = 1'b0;
    end else if (!freeze) begin
      e.alu = ALU_Res_in; e.rm = Val_Rm_in; e.dest = Dest_in;
      e.wb  = Valid_in ? WB_EN_in : 1'b0;
      e.mr  = Valid_in ? MEM_R_EN_in : 1'b0;
      e.mw  = Valid_in ? MEM_W_EN_in : 1'b0;
      e.vld = Valid_in;
      if (S && Valid_in) e.status = Status_Bits_in;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("status",   32'(Status),       32'(got.status));
    check_eq("c_out",    32'(C_out),        32'(got.status[1]));
    check_eq("alu_res",  ALU_Res_out,       got.alu);
    check_eq("val_rm",   Val_Rm_out,        got.rm);
    check_eq("dest",     32'(Dest_out),     32'(got.dest));
    check_eq("wb_en",    32'(WB_EN_out),    32'(got.wb));
    check_eq("mem_r_en", 32'(MEM_R_EN_out), 32'(got.mr));
    check_eq("mem_w_en", 32'(MEM_W_EN_out), 32'(got.mw));
    check_eq("valid",    32'(Valid_out),    32'(got.vld));
    m = got;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; freeze = 1'b0; Valid_in = 1'b0; S = 1'b0;
    Status_Bits_in = 4'h0; ALU_Res_in = 32'h0; Val_Rm_in = 32'h0;
    Dest_in = 4'h0; WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    Cond = 4'd14;
  endtask

  logic [3:0] sweep_cond [8] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd4, 4'd6, 4'd8, 4'd15};
  logic       sweep_exp  [8] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    m = '{status: 4'h0, alu: 32'h0, rm: 32'h0, dest: 4'h0, wb: 1'b0, mr: 1'b0, mw: 1'b0, vld: 1'b0};

    // Reset with every input nonzero.
    rst = 1'b1; freeze = 1'b1; Valid_in = 1'b1; S = 1'b1;
    Status_Bits_in = 4'hF; ALU_Res_in = 32'hDEAD_BEEF; Val_Rm_in = 32'hCAFE_F00D;
    Dest_in = 4'hA; WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; MEM_W_EN_in = 1'b1;
    Cond = 4'd5;
    step(1'b0);
    check_eq("rst_status_const", 32'(Status), 32'h0);
    clear_inputs();
    Cond = 4'd14; #1 check_eq("rst_cond_al", 32'(Cond_Pass), 32'h1);
    Cond = 4'd0;  #1 check_eq("rst_cond_eq", 32'(Cond_Pass), 32'h0);

    // Forwarding with Status = 0000.
    Valid_in = 1'b1; S = 1'b1; Status_Bits_in = 4'b0100; Cond = 4'd0;
    #1 check_eq("fwd_eq_s1", 32'(Cond_Pass), 32'h1);
    S = 1'b0;
    #1 check_eq("fwd_eq_s0", 32'(Cond_Pass), 32'h0);

    // Capture.
    S = 1'b1; ALU_Res_in = 32'h0000_0008; Dest_in = 4'd3; WB_EN_in = 1'b1;
    step(1'b1);
    check_eq("cap_status_const", 32'(Status), 32'h4);
    check_eq("cap_alu_const", ALU_Res_out, 32'h8);

    // Bubble.
    clear_inputs();
    S = 1'b1; MEM_W_EN_in = 1'b1; Status_Bits_in = 4'hF;
    step(1'b1);
    check_eq("bub_mw_const", 32'(MEM_W_EN_out), 32'h0);
    check_eq("bub_status_const", 32'(Status), 32'h4);

    // Freeze.
    clear_inputs();
    Valid_in = 1'b1; ALU_Res_in = 32'h14;
    step(1'b1);
    freeze = 1'b1; S = 1'b1; Status_Bits_in = 4'hB; ALU_Res_in = 32'h99;
    Dest_in = 4'd7; WB_EN_in = 1'b1; MEM_R_EN_in = 1'b1; Cond = 4'd2;
    for (int unsigned i = 0; i < 3; i++) step(1'b1);
    check_eq("frz_alu_const", ALU_Res_out, 32'h14);
    check_eq("frz_status_const", 32'(Status), 32'h4);
    freeze = 1'b0;
    step(1'b1);
    check_eq("rel_alu_const", ALU_Res_out, 32'h99);
    check_eq("rel_status_const", 32'(Status), 32'hB);

    // Reset during freeze.
    freeze = 1'b1; rst = 1'b1;
    step(1'b1);
    check_eq("rstfrz_alu_const", ALU_Res_out, 32'h0);

    // Condition sweep with Status = 1001.
    clear_inputs();
    Valid_in = 1'b1; S = 1'b1; Status_Bits_in = 4'b1001;
    step(1'b1);
    S = 1'b0; Status_Bits_in = 4'b0110;
    for (int unsigned i = 0; i < 16; i++) begin
      Cond = 4'(i);
      #1 check_eq("sweep_model", 32'(Cond_Pass), 32'(cond_model(Cond, 4'b1001)));
    end
    for (int unsigned i = 0; i < 8; i++) begin
      Cond = sweep_cond[i];
      #1 check_eq("sweep_const", 32'(Cond_Pass), 32'(sweep_exp[i]));
    end
    @(posedge clk); #1;

    // Randomised traffic, including back-to-back flag setters.
    for (int unsigned i = 0; i < 80; i++) begin
      rst         = ($urandom_range(0, 19) == 0);
      freeze      = ($urandom_range(0, 3) == 0);
      Valid_in    = ($urandom_range(0, 3) != 0);
      S           = ($urandom_range(0, 1) == 1);
      Status_Bits_in = 4'($urandom);
      ALU_Res_in  = $urandom;
      Val_Rm_in   = $urandom;
      Dest_in     = 4'($urandom);
      WB_EN_in    = 1'($urandom);
      MEM_R_EN_in = 1'($urandom);
      MEM_W_EN_in = 1'($urandom);
      Cond        = 4'($urandom);
      step(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
